// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: funct3 size codes, FSM
// states, and the decode helpers that check legality and build strobes and lane data.
package dmem_bus_bridge_pkg;

  localparam int WORD_LEN  = 32;
  localparam int ADDR_SIZE = 32;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Stores only have B/H/W encodings; unsigned variants are load-only.
  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] off,
                                     input logic is_store);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !is_store;
      SZ_H:    ok = !off[0];
      SZ_HU:   ok = !is_store && !off[0];
      SZ_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] strobe_for(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << off;
      SZ_H:    strb = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [WORD_LEN-1:0] lane_data(input logic [2:0] size,
                                                    input logic [WORD_LEN-1:0] wd);
    logic [WORD_LEN-1:0] d;
    case (size)
      SZ_B:    d = {4{wd[7:0]}};
      SZ_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Valid/ready memory bus between the bridge (master) and the memory (slave).
interface dmem_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_wstrb;
  logic [31:0]           bus_wdata;
  logic                  bus_rvalid;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/halfword lane of a bus word and
// sign- or zero-extends it according to the funct3 size code.
module dmem_load_align
  import dmem_bus_bridge_pkg::*;
(
  input  logic [WORD_LEN-1:0] word_i,
  input  logic [1:0]          off_i,
  input  logic [2:0]          size_i,
  output logic [WORD_LEN-1:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output is assigned on every path (case default), so no latch is inferred.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   data_o = {24'h0, byte_sel};
      SZ_H:    data_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   data_o = {16'h0, half_sel};
      SZ_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the MEM-stage data port onto a valid/ready bus with wait states,
// stalling the pipeline until each access completes, faults, or times out.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  readEnable,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            unitSize,
  input  logic [WORD_LEN-1:0]   writeData,
  output logic [WORD_LEN-1:0]   readData,
  output logic                  stall,
  output logic                  fault,
  dmem_bus_bridge_if.master     bus
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            wstrb_q;
  logic [WORD_LEN-1:0]   wdata_q;
  logic [2:0]            size_q;
  logic [1:0]            off_q;
  logic [7:0]            cnt_q;
  logic [WORD_LEN-1:0]   read_data_q;
  logic                  fault_q;
  logic [WORD_LEN-1:0]   load_result;
  logic                  access;

  assign access = readEnable | writeEnable;

  dmem_load_align u_align (
    .word_i (bus.bus_rdata),
    .off_i  (off_q),
    .size_i (size_q),
    .data_o (load_result)
  );

  // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      // readData and fault are only meaningful in DONE; clear them everywhere else.
      read_data_q <= '0;
      fault_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            if (!access_ok(unitSize, addr[1:0], writeEnable)) begin
              fault_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              we_q    <= writeEnable;
              wstrb_q <= writeEnable ? strobe_for(unitSize, addr[1:0]) : 4'b0000;
              wdata_q <= writeEnable ? lane_data(unitSize, writeData) : '0;
              size_q  <= unitSize;
              off_q   <= addr[1:0];
              cnt_q   <= '0;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.bus_ready) begin
            state_q <= we_q ? ST_DONE : ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            fault_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_RESP: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.bus_rvalid) begin
            read_data_q <= load_result;
            state_q     <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            fault_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ) || (state_q == ST_RESP);

  assign readData      = read_data_q;
  assign fault         = fault_q;
  assign bus.bus_valid = (state_q == ST_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;
endmodule
